// File: rtl/jpeg_pkg.sv
// Shared constants and types for the 8x8 JPEG quantisation datapath.
package jpeg_pkg;

  localparam int COEF_WIDTH = 11;
  localparam int BLOCK_LEN  = 64;

  typedef logic signed [COEF_WIDTH-1:0] coef_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_COUNT);

  // Guards stay local so the FIFO is safe even if a caller forgets them;
  // a pop frees the slot a same-cycle push needs when full.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_count     = r_count;

endmodule

// File: rtl/booth_quant_sink.sv
// Sink for the Booth multiplier chain: round, saturate, tag block position
// and buffer coefficients, with an issue credit that protects in-flight products.
module booth_quant_sink #(
  parameter int DIN_WIDTH  = 20,
  parameter int SHIFT      = 8,
  parameter int DOUT_WIDTH = jpeg_pkg::COEF_WIDTH,
  parameter int DEPTH      = 8,
  parameter int IN_FLIGHT  = 5,
  parameter int BLOCK_LEN  = jpeg_pkg::BLOCK_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din_product,
  input  logic                  din_valid,
  output logic                  issue_ok,
  output logic [DOUT_WIDTH-1:0] dout_coef,
  output logic                  dout_last,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  overflow
);

  localparam int EXT_W = DIN_WIDTH + 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int POS_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

  localparam logic signed [EXT_W-1:0] HALF     = EXT_W'(2 ** (SHIFT - 1));
  localparam logic signed [EXT_W-1:0] COEF_MAX = EXT_W'(2 ** (DOUT_WIDTH - 1) - 1);
  localparam logic signed [EXT_W-1:0] COEF_MIN = EXT_W'(-(2 ** (DOUT_WIDTH - 1)));
  localparam logic [CNT_W-1:0]        ISSUE_LIMIT = CNT_W'(DEPTH - IN_FLIGHT - 1);
  localparam logic [POS_W-1:0]        POS_LAST    = POS_W'(BLOCK_LEN - 1);

  generate
    if (DEPTH < IN_FLIGHT + 1) begin : g_bad_credit
      $error("booth_quant_sink: DEPTH must be at least IN_FLIGHT+1");
    end
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("booth_quant_sink: DEPTH must be a power of two and at least 4");
    end
    if (SHIFT < 1) begin : g_bad_shift
      $error("booth_quant_sink: SHIFT must be at least 1");
    end
  endgenerate

  logic signed [EXT_W-1:0]      w_ext;
  logic signed [EXT_W-1:0]      w_bias;
  logic signed [EXT_W-1:0]      w_rounded;
  logic signed [DOUT_WIDTH-1:0] w_sat;

  logic                  r_valid;
  logic [DOUT_WIDTH-1:0] r_coef;
  logic [POS_W-1:0]      r_pos;
  logic                  r_overflow;

  logic                  w_last;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic [DOUT_WIDTH:0]   w_head;

  // Round half away from zero: negatives get one less bias so the floor of
  // the arithmetic shift lands on the larger-magnitude neighbour at a tie.
  assign w_ext     = EXT_W'($signed(din_product));
  assign w_bias    = din_product[DIN_WIDTH-1] ? (HALF - EXT_W'(1)) : HALF;
  assign w_rounded = (w_ext + w_bias) >>> SHIFT;

  always_comb begin
    if (w_rounded > COEF_MAX) begin
      w_sat = DOUT_WIDTH'(COEF_MAX);
    end else if (w_rounded < COEF_MIN) begin
      w_sat = DOUT_WIDTH'(COEF_MIN);
    end else begin
      w_sat = DOUT_WIDTH'(w_rounded);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= din_valid;
    end
    r_coef <= w_sat;
  end

  // Position advances on every stage-R word, including dropped ones, so block
  // alignment survives an overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos <= '0;
    end else if (r_valid) begin
      r_pos <= (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
    end
  end

  assign w_last = (r_pos == POS_LAST);
  assign w_pop  = dout_valid & dout_ready;
  assign w_push = r_valid & (~w_full | w_pop);
  assign w_drop = r_valid & ~w_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DOUT_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data ({w_last, r_coef}),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign dout_valid = ~w_empty;
  assign dout_coef  = w_head[DOUT_WIDTH-1:0];
  assign dout_last  = w_head[DOUT_WIDTH] & ~w_empty;
  assign overflow   = r_overflow;
  // Credit depends on occupancy only, never on this cycle's dout_ready.
  assign issue_ok   = (w_count <= ISSUE_LIMIT);

endmodule

// File: tb/tb_booth_quant_sink.sv
// Randomised bench for booth_quant_sink against a queue-based reference model.
module tb_booth_quant_sink;

  localparam int DW    = 20;
  localparam int SH    = 8;
  localparam int OW    = 11;
  localparam int DEPTH = 8;
  localparam int INF   = 5;
  localparam int BL    = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din_product;
  logic          din_valid;
  logic          issue_ok;
  logic [OW-1:0] dout_coef;
  logic          dout_last;
  logic          dout_valid;
  logic          dout_ready;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_quant_sink #(
    .DIN_WIDTH(DW), .SHIFT(SH), .DOUT_WIDTH(OW),
    .DEPTH(DEPTH), .IN_FLIGHT(INF), .BLOCK_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst), .din_product(din_product), .din_valid(din_valid),
    .issue_ok(issue_ok), .dout_coef(dout_coef), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .overflow(overflow)
  );

  // Reference: magnitude rounding with plain integer division, then clamp.
  function automatic jpeg_pkg::coef_t ref_q(input int p);
    int mag;
    int q;
    mag = (p < 0) ? -p : p;
    q = (mag + (1 << (SH - 1))) / (1 << SH);
    if (p < 0) q = -q;
    if (q > (1 << (OW - 1)) - 1) q = (1 << (OW - 1)) - 1;
    if (q < -(1 << (OW - 1))) q = -(1 << (OW - 1));
    return jpeg_pkg::coef_t'(q);
  endfunction

  function automatic int rand_prod();
    logic [DW-1:0] r;
    r = DW'($urandom);
    if ($urandom_range(0, 3) != 0) r = DW'(int'($urandom_range(0, 4000)) - 2000);
    return int'($signed(r));
  endfunction

  typedef struct {
    jpeg_pkg::coef_t coef;
    logic            last;
  } ent_t;

  ent_t mq[$];
  logic m_sv  = 1'b0;
  int   m_sp  = 0;
  int   m_pos = 0;
  logic m_ovf = 1'b0;

  // Model: one registered stage, then a bounded queue of DEPTH entries.
  always @(posedge clk) begin : model
    ent_t e;
    if (rst) begin
      mq.delete();
      m_sv  = 1'b0;
      m_pos = 0;
      m_ovf = 1'b0;
    end else begin
      if (mq.size() > 0 && dout_ready) void'(mq.pop_front());
      if (m_sv) begin
        e.coef = ref_q(m_sp);
        e.last = (m_pos == BL - 1);
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1'b1;
        m_pos = (m_pos + 1) % BL;
      end
      m_sv = din_valid;
      m_sp = int'($signed(din_product));
    end
  end

  task automatic drive(input logic v, input int p, input logic rdy);
    din_valid   = v;
    din_product = DW'(p);
    dout_ready  = rdy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h400, 1'b0);
    drive(1'b1, 32'h400, 1'b0);
    checks += 4;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    if (dout_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", dout_last); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    if (issue_ok !== 1'b1) begin errors++; $display("FAIL reset_issue_ok got %b want 1", issue_ok); end
    rst = 1'b0;
    drive(1'b0, 0, 1'b0);
    drive(1'b0, 0, 1'b0);
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_ignores_din got valid %b want 0", dout_valid); end
    $display("test_reset done");
  endtask

  task automatic test_rounding();
    int prods[6] = '{384, 128, -128, -384, 524287, -524288};
    int expv[6]  = '{2, 1, -1, -2, 1023, -1024};
    for (int i = 0; i < 6; i++) drive(1'b1, prods[i], 1'b0);
    drive(1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dout_valid !== 1'b1 || int'($signed(dout_coef)) !== expv[i]) begin
        errors++;
        $display("FAIL rounding[%0d] got valid %b coef %0d want 1 %0d", i, dout_valid, $signed(dout_coef), expv[i]);
      end
      $display("rounding product %0d -> %0d", prods[i], $signed(dout_coef));
      drive(1'b0, 0, 1'b1);
    end
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL rounding_empty got valid %b want 0", dout_valid); end
  endtask

  task automatic test_latency_last();
    int popped = 0;
    int nlast = 0;
    int last_idx = -1;
    int first_cyc = -1;
    rst = 1'b1;
    drive(1'b0, 0, 1'b1);
    rst = 1'b0;
    for (int c = 0; c < 70; c++) begin
      drive(c < 65, rand_prod(), 1'b1);
      if (dout_valid && first_cyc < 0) first_cyc = c + 1;
      checks++;
      if (dout_valid !== (mq.size() > 0) || issue_ok !== (mq.size() <= DEPTH - INF - 1) || overflow !== m_ovf) begin
        errors++;
        $display("FAIL latency_status got v%b i%b o%b want v%b i%b o%b", dout_valid, issue_ok, overflow,
                 mq.size() > 0, mq.size() <= DEPTH - INF - 1, m_ovf);
      end
      if (mq.size() > 0) begin
        checks++;
        if (dout_coef !== mq[0].coef || dout_last !== mq[0].last) begin
          errors++;
          $display("FAIL latency_head got %0d/%b want %0d/%b", $signed(dout_coef), dout_last, mq[0].coef, mq[0].last);
        end
      end
      if (dout_valid) begin
        if (dout_last) begin nlast++; last_idx = popped; end
        popped++;
      end
    end
    checks += 4;
    if (first_cyc !== 2) begin errors++; $display("FAIL first_valid_latency got %0d want 2", first_cyc); end
    if (nlast !== 1) begin errors++; $display("FAIL last_count got %0d want 1", nlast); end
    if (last_idx !== 63) begin errors++; $display("FAIL last_index got %0d want 63", last_idx); end
    if (popped !== 65) begin errors++; $display("FAIL latency_popped got %0d want 65", popped); end
    $display("latency first_valid=%0d popped=%0d last_idx=%0d", first_cyc, popped, last_idx);
  endtask

  task automatic test_credit();
    logic [INF-2:0] pipe = '0;
    logic iss;
    int pops = 0;
    for (int c = 0; c < 34; c++) begin
      iss = (c < 30) ? issue_ok : 1'b0;
      drive(pipe[INF-2], rand_prod(), 1'b0);
      pipe = {pipe[INF-3:0], iss};
      checks++;
      if (dout_valid !== (mq.size() > 0) || issue_ok !== (mq.size() <= DEPTH - INF - 1) || overflow !== m_ovf) begin
        errors++;
        $display("FAIL credit_status got v%b i%b o%b want v%b i%b o%b", dout_valid, issue_ok, overflow,
                 mq.size() > 0, mq.size() <= DEPTH - INF - 1, m_ovf);
      end
    end
    drive(1'b0, 0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL credit_overflow got %b want 0", overflow); end
    for (int c = 0; c < 12; c++) begin
      if (dout_valid) begin
        checks++;
        if (dout_coef !== mq[0].coef) begin
          errors++;
          $display("FAIL credit_drain got %0d want %0d", $signed(dout_coef), mq[0].coef);
        end
        pops++;
      end
      drive(1'b0, 0, 1'b1);
    end
    checks++;
    if (pops !== DEPTH) begin errors++; $display("FAIL credit_peak got %0d want %0d", pops, DEPTH); end
    $display("credit peak occupancy %0d", pops);
  endtask

  task automatic test_overflow();
    int prods[10];
    int pops = 0;
    for (int i = 0; i < 10; i++) begin
      prods[i] = rand_prod();
      drive(1'b1, prods[i], 1'b0);
    end
    drive(1'b0, 0, 1'b0);
    drive(1'b0, 0, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b want 1", overflow); end
    for (int c = 0; c < 12; c++) begin
      if (dout_valid) begin
        checks++;
        if (pops >= 8 || dout_coef !== ref_q(prods[pops])) begin
          errors++;
          $display("FAIL overflow_drain[%0d] got %0d", pops, $signed(dout_coef));
        end
        pops++;
      end
      drive(1'b0, 0, 1'b1);
    end
    checks += 2;
    if (pops !== 8) begin errors++; $display("FAIL overflow_kept got %0d want 8", pops); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b want 1", overflow); end
    $display("overflow stored %0d of 10", pops);
  endtask

  task automatic test_full_pushpop();
    int pops = 0;
    rst = 1'b1;
    drive(1'b0, 0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) drive(1'b1, rand_prod(), 1'b0);
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, rand_prod(), 1'b1);
      checks++;
      if (dout_valid !== 1'b1 || issue_ok !== 1'b0 || overflow !== 1'b0 || mq.size() != DEPTH) begin
        errors++;
        $display("FAIL full_status got v%b i%b o%b model count %0d", dout_valid, issue_ok, overflow, mq.size());
      end
      if (mq.size() > 0) begin
        checks++;
        if (dout_coef !== mq[0].coef || dout_last !== mq[0].last) begin
          errors++;
          $display("FAIL full_head got %0d/%b want %0d/%b", $signed(dout_coef), dout_last, mq[0].coef, mq[0].last);
        end
      end
    end
    drive(1'b0, 0, 1'b1);
    drive(1'b0, 0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      if (dout_valid) pops++;
      drive(1'b0, 0, 1'b1);
    end
    checks += 2;
    if (pops !== DEPTH) begin errors++; $display("FAIL full_kept got %0d want %0d", pops, DEPTH); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow got %b want 0", overflow); end
    $display("full push+pop held %0d entries", pops);
  endtask

  task automatic test_reset_mid();
    int popped = 0;
    int nlast = 0;
    int last_idx = -1;
    rst = 1'b1;
    drive(1'b0, 0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) drive(1'b1, rand_prod(), i < 25);
    checks++;
    if (dout_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got valid %b want 1", dout_valid); end
    rst = 1'b1;
    drive(1'b1, rand_prod(), 1'b0);
    rst = 1'b0;
    checks += 3;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", dout_valid); end
    if (issue_ok !== 1'b1) begin errors++; $display("FAIL midrst_issue got %b want 1", issue_ok); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b want 0", overflow); end
    for (int c = 0; c < 68; c++) begin
      drive(c < 64, rand_prod(), 1'b1);
      if (mq.size() > 0) begin
        checks++;
        if (dout_valid !== 1'b1 || dout_coef !== mq[0].coef || dout_last !== mq[0].last) begin
          errors++;
          $display("FAIL midrst_head got v%b %0d/%b want %0d/%b", dout_valid, $signed(dout_coef), dout_last,
                   mq[0].coef, mq[0].last);
        end
      end
      if (dout_valid) begin
        if (dout_last) begin nlast++; last_idx = popped; end
        popped++;
      end
    end
    checks += 2;
    if (nlast !== 1) begin errors++; $display("FAIL midrst_last_count got %0d want 1", nlast); end
    if (last_idx !== 63) begin errors++; $display("FAIL midrst_last_index got %0d want 63", last_idx); end
    $display("reset mid-block: popped=%0d last_idx=%0d", popped, last_idx);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive($urandom_range(0, 9) < 7, rand_prod(), $urandom_range(0, 9) < 6);
      checks++;
      if (dout_valid !== (mq.size() > 0) || issue_ok !== (mq.size() <= DEPTH - INF - 1) || overflow !== m_ovf) begin
        errors++;
        $display("FAIL random_status got v%b i%b o%b want v%b i%b o%b", dout_valid, issue_ok, overflow,
                 mq.size() > 0, mq.size() <= DEPTH - INF - 1, m_ovf);
      end
      if (mq.size() > 0) begin
        checks++;
        if (dout_coef !== mq[0].coef || dout_last !== mq[0].last) begin
          errors++;
          $display("FAIL random_head got %0d/%b want %0d/%b", $signed(dout_coef), dout_last, mq[0].coef, mq[0].last);
        end
      end
    end
    $display("random run complete, overflow=%b", overflow);
  endtask

  initial begin
    rst         = 1'b1;
    din_valid   = 1'b0;
    din_product = '0;
    dout_ready  = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_rounding();
    test_latency_last();
    test_credit();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
